// File: rtl/c17_diag_pkg.sv
// c17_diag_pkg: shared types, widths and the ordered candidate fault list for
// the c17 fault diagnoser.
// Optional feature macro: C17_DIAG_FAULT_FREE_EN adds opcode 6'h00 (fault-free)
// as the first candidate.
// Opcode encoding: opcode[5:1] = fault site id (0 = no fault), opcode[0] = stuck value.
package c17_diag_pkg;

   localparam int unsigned NUM_FAULTS   = 22;
   localparam int unsigned PATTERN_W    = 5;
   localparam int unsigned OPCODE_W     = 6;
   localparam int unsigned NUM_PATTERNS = 1 << PATTERN_W;
   localparam int unsigned CAND_W       = 5;
   localparam int unsigned COUNT_W      = 5;
   localparam int unsigned RESP_W       = 2;

`ifdef C17_DIAG_FAULT_FREE_EN
   localparam int unsigned NUM_CAND = NUM_FAULTS + 1;
`else
   localparam int unsigned NUM_CAND = NUM_FAULTS;
`endif

   typedef enum logic [1:0] {
      ST_COLLECT = 2'd0,
      ST_SWEEP   = 2'd1,
      ST_EMIT    = 2'd2,
      ST_DONE    = 2'd3
   } diag_state_e;

   typedef logic [OPCODE_W-1:0] opcode_t;

   // One observation beat as offered on the obs_* port group.
   typedef struct packed {
      logic [PATTERN_W-1:0] pattern;
      logic [RESP_W-1:0]    resp;   // {N22, N23}
      logic                 last;
   } obs_beat_t;

   localparam opcode_t FAULT_LIST [NUM_FAULTS] = '{
      6'h03, 6'h11, 6'h13, 6'h07, 6'h06, 6'h0D, 6'h05, 6'h0F, 6'h15, 6'h29, 6'h21,
      6'h20, 6'h27, 6'h2B, 6'h2D, 6'h2C, 6'h2F, 6'h2E, 6'h17, 6'h16, 6'h1D, 6'h1F
   };

   // Maps a candidate index to its opcode in list order.
   function automatic opcode_t cand_opcode(input logic [CAND_W-1:0] idx);
      logic [CAND_W-1:0] k;
      k = idx;
`ifdef C17_DIAG_FAULT_FREE_EN
      if (k == '0) begin
         return '0;
      end
      k = k - CAND_W'(1);
`endif
      if (k >= CAND_W'(NUM_FAULTS)) begin
         return '0;
      end
      return FAULT_LIST[k];
   endfunction

endpackage

// File: rtl/c17_fault_diagnoser_netlist.sv
// c17_fault_diagnoser_netlist: ISCAS c17 NAND netlist with single stuck-at
// injection selected by an opcode. Combinational.
// Ports: pattern  - {N7,N6,N3,N2,N1} applied vector
//        opcode   - {site[4:0], stuck}; site 0 means fault-free
//        n22_c/n23_c - resulting primary outputs
// Site ids: 1=N1 2=N2 3=N3 6=N6 7=N7 8=N3->N10 9=N3->N11 10=N10 11=N11
//           14=N11->N16 15=N11->N19 16=N16 19=N19 20=N16->N22 21=N16->N23
//           22=N22 23=N23
module c17_fault_diagnoser_netlist
   import c17_diag_pkg::*;
(
   input  logic [PATTERN_W-1:0] pattern,
   input  logic [OPCODE_W-1:0]  opcode,
   output logic                 n22_c,
   output logic                 n23_c
);

   logic [4:0] site;
   logic       stuck;

   assign site  = opcode[5:1];
   assign stuck = opcode[0];

   // Replace a line value with the stuck value when the site is selected.
   function automatic logic inj(input logic val, input logic [4:0] id,
                                input logic [4:0] sel, input logic sv);
      return (sel == id) ? sv : val;
   endfunction

   logic n1, n2, n3, n6, n7, n3a, n3b, n10, n11, n11a, n11b;
   logic n16, n19, n16a, n16b;

   always_comb begin
      n1    = inj(pattern[0], 5'd1, site, stuck);
      n2    = inj(pattern[1], 5'd2, site, stuck);
      n3    = inj(pattern[2], 5'd3, site, stuck);
      n6    = inj(pattern[3], 5'd6, site, stuck);
      n7    = inj(pattern[4], 5'd7, site, stuck);
      n3a   = inj(n3, 5'd8, site, stuck);
      n3b   = inj(n3, 5'd9, site, stuck);
      n10   = inj(~(n1 & n3a), 5'd10, site, stuck);
      n11   = inj(~(n3b & n6), 5'd11, site, stuck);
      n11a  = inj(n11, 5'd14, site, stuck);
      n11b  = inj(n11, 5'd15, site, stuck);
      n16   = inj(~(n2 & n11a), 5'd16, site, stuck);
      n19   = inj(~(n11b & n7), 5'd19, site, stuck);
      n16a  = inj(n16, 5'd20, site, stuck);
      n16b  = inj(n16, 5'd21, site, stuck);
      n22_c = inj(~(n10 & n16a), 5'd22, site, stuck);
      n23_c = inj(~(n16b & n19), 5'd23, site, stuck);
   end

endmodule

// File: rtl/c17_fault_diagnoser.sv
// c17_fault_diagnoser: collects (pattern, N22/N23) observations, then sweeps
// every candidate fault opcode over all 32 pattern indices and emits each
// candidate consistent with all seen observations.
// Ports: clk, rst (async, active-high)
//        obs_valid/obs_ready/obs_pattern/obs_n22/obs_n23/obs_last - observation input
//        res_valid/res_ready/res_opcode - consistent-candidate output stream
//        done - diagnosis finished; match_count - candidates emitted this diagnosis
// Optional feature macro: C17_DIAG_FAULT_FREE_EN (fault-free opcode 00 as first candidate).
module c17_fault_diagnoser
   import c17_diag_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 obs_valid,
   output logic                 obs_ready,
   input  logic [PATTERN_W-1:0] obs_pattern,
   input  logic                 obs_n22,
   input  logic                 obs_n23,
   input  logic                 obs_last,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [OPCODE_W-1:0]  res_opcode,
   output logic                 done,
   output logic [COUNT_W-1:0]   match_count
);

   diag_state_e              state_q, state_d;
   logic [RESP_W-1:0]        buf_q [NUM_PATTERNS];
   logic [RESP_W-1:0]        buf_d [NUM_PATTERNS];
   logic [NUM_PATTERNS-1:0]  seen_q, seen_d;
   logic [CAND_W-1:0]        cand_q, cand_d;
   logic [PATTERN_W-1:0]     pat_q, pat_d;
   logic                     mism_q, mism_d;
   logic [COUNT_W-1:0]       match_count_q, match_count_d;
   logic                     res_valid_q, res_valid_d;
   logic [OPCODE_W-1:0]      res_opcode_q, res_opcode_d;
   logic                     done_q, done_d;
   logic                     obs_ready_q, obs_ready_d;

   obs_beat_t                beat_c;
   opcode_t                  cand_op_c;
   logic                     model_n22_c, model_n23_c;
   logic                     beat_fire_c, last_cand_c, mismatch_c, fail_c;

   assign beat_c.pattern = obs_pattern;
   assign beat_c.resp    = {obs_n22, obs_n23};
   assign beat_c.last    = obs_last;

   assign cand_op_c   = cand_opcode(cand_q);
   assign beat_fire_c = obs_valid && obs_ready_q;
   assign last_cand_c = (cand_q == CAND_W'(NUM_CAND - 1));

   // Single response model; the opcode meaning lives only in the netlist.
   c17_fault_diagnoser_netlist u_model (
      .pattern (pat_q),
      .opcode  (cand_op_c),
      .n22_c   (model_n22_c),
      .n23_c   (model_n23_c)
   );

   // Unseen indices never count as a mismatch.
   assign mismatch_c = seen_q[pat_q] && ({model_n22_c, model_n23_c} != buf_q[pat_q]);
   assign fail_c     = mism_q || mismatch_c;

   // Next-state and registered-output logic.
   always_comb begin
      state_d       = state_q;
      buf_d         = buf_q;
      seen_d        = seen_q;
      cand_d        = cand_q;
      pat_d         = pat_q;
      mism_d        = mism_q;
      match_count_d = match_count_q;
      res_valid_d   = res_valid_q;
      res_opcode_d  = res_opcode_q;
      done_d        = done_q;

      unique case (state_q)
         ST_COLLECT, ST_DONE: begin
            if (beat_fire_c) begin
               // A beat taken in DONE starts a new set from a clean slate.
               if (state_q == ST_DONE) begin
                  seen_d        = '0;
                  match_count_d = '0;
                  done_d        = 1'b0;
               end
               buf_d[beat_c.pattern]  = beat_c.resp;
               seen_d[beat_c.pattern] = 1'b1;
               state_d = beat_c.last ? ST_SWEEP : ST_COLLECT;
               cand_d  = '0;
               pat_d   = '0;
               mism_d  = 1'b0;
            end
         end
         ST_SWEEP: begin
            if (pat_q == PATTERN_W'(NUM_PATTERNS - 1)) begin
               pat_d  = '0;
               mism_d = 1'b0;
               if (!fail_c) begin
                  state_d      = ST_EMIT;
                  res_valid_d  = 1'b1;
                  res_opcode_d = cand_op_c;
               end else if (last_cand_c) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  cand_d = cand_q + CAND_W'(1);
               end
            end else begin
               pat_d  = pat_q + PATTERN_W'(1);
               mism_d = fail_c;
            end
         end
         ST_EMIT: begin
            if (res_ready) begin
               res_valid_d   = 1'b0;
               match_count_d = match_count_q + COUNT_W'(1);
               if (last_cand_c) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_SWEEP;
                  cand_d  = cand_q + CAND_W'(1);
               end
            end
         end
         default: state_d = ST_COLLECT;
      endcase

      obs_ready_d = (state_d == ST_COLLECT) || (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_COLLECT;
         buf_q         <= '{default: '0};
         seen_q        <= '0;
         cand_q        <= '0;
         pat_q         <= '0;
         mism_q        <= 1'b0;
         match_count_q <= '0;
         res_valid_q   <= 1'b0;
         res_opcode_q  <= '0;
         done_q        <= 1'b0;
         obs_ready_q   <= 1'b1;
      end else begin
         state_q       <= state_d;
         buf_q         <= buf_d;
         seen_q        <= seen_d;
         cand_q        <= cand_d;
         pat_q         <= pat_d;
         mism_q        <= mism_d;
         match_count_q <= match_count_d;
         res_valid_q   <= res_valid_d;
         res_opcode_q  <= res_opcode_d;
         done_q        <= done_d;
         obs_ready_q   <= obs_ready_d;
      end
   end

   assign obs_ready   = obs_ready_q;
   assign res_valid   = res_valid_q;
   assign res_opcode  = res_opcode_q;
   assign done        = done_q;
   assign match_count = match_count_q;

endmodule
